// File: rtl/noc_pkg.sv
// Shared NoC definitions for the injector slice.
//   flit_type_e : flit type carried in bits [TYPE_MSB:TYPE_LSB]
//   inj_state_e : injector handshake FSM states
//   field localparams locate the head-flit routing fields.
package noc_pkg;

  typedef enum logic [1:0] {
    BODY    = 2'b00,
    HEAD    = 2'b01,
    TAIL    = 2'b10,
    ILLEGAL = 2'b11
  } flit_type_e;

  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;
  localparam int LOC_MSB  = 4;
  localparam int LOC_LSB  = 2;
  localparam int Y_MSB    = 8;
  localparam int Y_LSB    = 5;
  localparam int X_MSB    = 12;
  localparam int X_LSB    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    WAIT  = 2'b10
  } inj_state_e;

endpackage

// File: rtl/inj_fifo.sv
// Synchronous flit FIFO.
// Ports:
//   clk, reset (async, active-low)
//   push, wr_data   : write, ignored when full
//   pop, rd_data    : rd_data is the current head; pop ignored when empty
//   full, empty     : derived from the registered occupancy count
//   count           : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module inj_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sync_async_injector.sv
// Network-interface injector: clocked valid/ready flit input, FIFO buffer,
// 2-phase bundled-data request/ack output toward the switch input port.
// Ports:
//   clk, reset              core clock, async active-low reset
//   flit_valid_i/data_i     core flit input
//   flit_ready_o            1 = FIFO can take a flit (0 while in reset)
//   req_up_o, Data_up_o     2-phase request and bundled data to the switch
//   ack_up_i                asynchronous 2-phase ack from the switch
//   busy_o                  FIFO non-empty or handshake outstanding
//   err_o                   sticky framing error
// Optional: define INJ_STATS_EN to add pkt_cnt_o / flit_cnt_o delivery counters.
//
// state | meaning
// IDLE  | waiting for a buffered flit with the previous handshake closed
// SETUP | Data_up_o loaded, counting bundling margin before req toggles
// WAIT  | req toggled, waiting for synchronized ack to match, then pop
module sync_async_injector
  import noc_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_valid_i,
  input  logic [WORD_WIDTH-1:0] flit_data_i,
  output logic                  flit_ready_o,
  output logic                  req_up_o,
  output logic [WORD_WIDTH-1:0] Data_up_o,
  input  logic                  ack_up_i,
  output logic                  busy_o,
  output logic                  err_o
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]           pkt_cnt_o,
  output logic [15:0]           flit_cnt_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  logic                   run_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   in_pkt_q;
  logic                   err_q;
  logic                   accept;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  logic [WORD_WIDTH-1:0]  fifo_head;
  flit_type_e             in_type;

  inj_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic [WORD_WIDTH-1:0]  data_q, data_d;

  // run_q keeps ready low while reset is held even though the FIFO is empty.
  assign flit_ready_o = run_q && !fifo_full;
  assign accept       = flit_valid_i && flit_ready_o;
  assign in_type      = flit_type_e'(flit_data_i[TYPE_MSB:TYPE_LSB]);
  assign fifo_push    = accept && (in_type != ILLEGAL);
  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign req_up_o     = req_q;
  assign Data_up_o    = data_q;
  assign err_o        = err_q;
  assign busy_o       = (fifo_count != '0) || (state_q != IDLE);

  inj_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (flit_data_i),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      run_q  <= 1'b1;
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_up_i};
    end
  end

  // Malformed flits other than type 11 are still forwarded; only the flag records them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      case (in_type)
        HEAD: begin
          if (in_pkt_q) err_q <= 1'b1;
          in_pkt_q <= 1'b1;
        end
        TAIL: begin
          if (!in_pkt_q) err_q <= 1'b1;
          in_pkt_q <= 1'b0;
        end
        BODY: begin
          if (!in_pkt_q) err_q <= 1'b1;
        end
        default: err_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // Data only moves in IDLE with ack_s==req, so it is frozen across the open phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (ack_s == req_q)) begin
          data_d  = fifo_head;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          req_d   = ~req_q;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (ack_s == req_q) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INJ_STATS_EN
  // data_q still holds the flit being popped, so its type marks packet completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_o  <= '0;
      flit_cnt_o <= '0;
    end else if (fifo_pop) begin
      flit_cnt_o <= flit_cnt_o + 16'd1;
      if (data_q[TYPE_MSB:TYPE_LSB] == TAIL) pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end
`endif

endmodule
